// File: rtl/game_pkg.sv
// Shared game-level definitions: controller state encoding, colours and
// the fixed lane/row geometry of the player block.
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INPUT,
      ST_ERASE,
      ST_UPDATE,
      ST_SETTLE,
      ST_DRAW
   } state_e;

   localparam logic [2:0] COLOUR_PLAYER = 3'b111;
   localparam logic [2:0] COLOUR_BG     = 3'b000;

   localparam int         NUM_LANES = 4;
   localparam logic [7:0] LANE_X [NUM_LANES] = '{8'd14, 8'd54, 8'd94, 8'd134};
   localparam logic [6:0] PLAYER_Y = 7'd99;

endpackage

// File: rtl/block_pixel_scanner.sv
// Raster-scans a BLOCK_W x BLOCK_H rectangle from a base point, emitting one
// registered pixel write per cycle; shared by player, enemy and bullet drawing.
module block_pixel_scanner
   import game_pkg::*;
#(
   parameter int BLOCK_W = 12,
   parameter int BLOCK_H = 8
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic [7:0] base_x,
   input  logic [6:0] base_y,
   input  logic [2:0] colour,
   output logic       plot,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       done
);

   logic [3:0] px_q, px_d;
   logic [3:0] py_q, py_d;
   logic [7:0] bx_q, bx_d;
   logic [6:0] by_q, by_d;
   logic       plot_q, plot_d;
   logic [7:0] vga_x_q, vga_x_d;
   logic [6:0] vga_y_q, vga_y_d;
   logic [2:0] vga_colour_q, vga_colour_d;
   logic       last_pixel;

   // High while the final pixel of the rectangle is on the bus.
   assign last_pixel = plot_q && (px_q == 4'(BLOCK_W - 1)) && (py_q == 4'(BLOCK_H - 1));

   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      px_d         = px_q;
      py_d         = py_q;
      bx_d         = bx_q;
      by_d         = by_q;
      plot_d       = plot_q;
      vga_x_d      = vga_x_q;
      vga_y_d      = vga_y_q;
      vga_colour_d = vga_colour_q;
      if (start) begin
         px_d         = '0;
         py_d         = '0;
         bx_d         = base_x;
         by_d         = base_y;
         plot_d       = 1'b1;
         vga_x_d      = base_x;
         vga_y_d      = base_y;
         vga_colour_d = colour;
      end else if (plot_q) begin
         if (last_pixel) begin
            plot_d = 1'b0;
            px_d   = '0;
            py_d   = '0;
         end else begin
            if (px_q == 4'(BLOCK_W - 1)) begin
               px_d = '0;
               py_d = py_q + 4'd1;
            end else begin
               px_d = px_q + 4'd1;
            end
            vga_x_d = bx_q + {4'b0000, px_d};
            vga_y_d = by_q + {3'b000, py_d};
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         px_q         <= '0;
         py_q         <= '0;
         bx_q         <= '0;
         by_q         <= '0;
         plot_q       <= 1'b0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
      end else begin
         px_q         <= px_d;
         py_q         <= py_d;
         bx_q         <= bx_d;
         by_q         <= by_d;
         plot_q       <= plot_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_colour_q <= vga_colour_d;
      end
   end

   assign plot       = plot_q;
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign done       = last_pixel;

endmodule

// File: rtl/player_move_sequencer.sv
// Frame-rate player controller: samples A/D once per frame, erases the block,
// steps the position register and redraws the block at the new x.
module player_move_sequencer
   import game_pkg::*;
#(
   parameter int         BLOCK_W       = 12,
   parameter int         BLOCK_H       = 8,
   parameter logic [2:0] PLAYER_COLOUR = COLOUR_PLAYER,
   parameter logic [2:0] BG_COLOUR     = COLOUR_BG
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       frame_tick,
   input  logic       keyboardAPressed,
   input  logic       keyboardDPressed,
   input  logic [7:0] x_current,
   input  logic [6:0] y_current,
   output logic       inputState,
   output logic       setAState,
   output logic       setDState,
   output logic       updateState,
   output logic       plot,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       busy
);

   state_e     state_q, state_d;
   logic       need_draw_q, need_draw_d;
   logic       input_q, input_d;
   logic       set_a_q, set_a_d;
   logic       set_d_q, set_d_d;
   logic       update_q, update_d;
   logic       busy_q, busy_d;
   logic       move_req;
   logic       scan_start;
   logic [2:0] scan_colour;
   logic       scan_done;

   // The key sample taken on the tick is carried by the set pulses themselves.
   assign move_req    = set_a_q | set_d_q;
   assign scan_start  = ((state_q == ST_INPUT) && move_req) || (state_q == ST_SETTLE);
   assign scan_colour = (state_q == ST_SETTLE) ? PLAYER_COLOUR : BG_COLOUR;

   block_pixel_scanner #(
      .BLOCK_W (BLOCK_W),
      .BLOCK_H (BLOCK_H)
   ) u_scanner (
      .clk        (clk),
      .resetn     (resetn),
      .start      (scan_start),
      .base_x     (x_current),
      .base_y     (y_current),
      .colour     (scan_colour),
      .plot       (plot),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .done       (scan_done)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         need_draw_q <= 1'b1;
         input_q     <= 1'b0;
         set_a_q     <= 1'b0;
         set_d_q     <= 1'b0;
         update_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         need_draw_q <= need_draw_d;
         input_q     <= input_d;
         set_a_q     <= set_a_d;
         set_d_q     <= set_d_d;
         update_q    <= update_d;
         busy_q      <= busy_d;
      end
   end

   // Ticks outside IDLE are simply not looked at, so they are dropped.
   always_comb begin
      state_d     = state_q;
      need_draw_d = need_draw_q;
      unique case (state_q)
         ST_IDLE:   if (frame_tick) state_d = ST_INPUT;
         ST_INPUT: begin
            if (move_req)         state_d = ST_ERASE;
            else if (need_draw_q) state_d = ST_SETTLE;
            else                  state_d = ST_IDLE;
         end
         ST_ERASE:  if (scan_done) state_d = ST_UPDATE;
         ST_UPDATE: state_d = ST_SETTLE;
         ST_SETTLE: state_d = ST_DRAW;
         ST_DRAW: begin
            if (scan_done) begin
               state_d     = ST_IDLE;
               need_draw_d = 1'b0;
            end
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   // Registered outputs are computed from the next state so they line up with it.
   always_comb begin
      input_d  = (state_d == ST_INPUT);
      set_a_d  = (state_q == ST_IDLE) && frame_tick && keyboardAPressed;
      set_d_d  = (state_q == ST_IDLE) && frame_tick && !keyboardAPressed && keyboardDPressed;
      update_d = (state_d == ST_UPDATE);
      busy_d   = (state_d != ST_IDLE);
   end

   assign inputState  = input_q;
   assign setAState   = set_a_q;
   assign setDState   = set_d_q;
   assign updateState = update_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_player_move_sequencer.sv
// Directed bench for player_move_sequencer with a lane-based position
// register, a pixel scoreboard and per-frame pulse/latency checks.
module tb_player_move_sequencer;

   localparam int W_PIX = 12;
   localparam int H_PIX = 8;
   localparam int PIX   = W_PIX * H_PIX;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   logic       clk = 1'b0;
   logic       resetn;
   logic       frame_tick;
   logic       key_a, key_d;
   logic [7:0] x_current;
   logic [6:0] y_current;
   logic       inputState, setAState, setDState, updateState, plot, busy;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;

   int n_checks = 0;
   int n_fail   = 0;

   pix_t exp_q[$];
   pix_t mon_exp;
   int   cyc = 0;
   int   first_plot_cyc = -1;
   int   cnt_a = 0, cnt_d = 0, cnt_upd = 0, cnt_in = 0, cnt_plot = 0;

   int   env_idx;
   int   env_dir;
   int   m_idx = 0;
   bit   m_need = 1'b1;

   always #5 clk = ~clk;

   player_move_sequencer dut (
      .clk              (clk),
      .resetn           (resetn),
      .frame_tick       (frame_tick),
      .keyboardAPressed (key_a),
      .keyboardDPressed (key_d),
      .x_current        (x_current),
      .y_current        (y_current),
      .inputState       (inputState),
      .setAState        (setAState),
      .setDState        (setDState),
      .updateState      (updateState),
      .plot             (plot),
      .vga_x            (vga_x),
      .vga_y            (vga_y),
      .vga_colour       (vga_colour),
      .busy             (busy)
   );

   function automatic int lane_x(input int idx);
      return 14 + 40 * idx;
   endfunction

   // Saturating lane position register driven by the sequencer's pulses.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         env_idx <= 0;
         env_dir <= 0;
      end else begin
         if (setAState)      env_dir <= -1;
         else if (setDState) env_dir <= 1;
         if (updateState) begin
            if (env_idx + env_dir < 0)      env_idx <= 0;
            else if (env_idx + env_dir > 3) env_idx <= 3;
            else                            env_idx <= env_idx + env_dir;
         end
      end
   end
   assign x_current = 8'(lane_x(env_idx));
   assign y_current = 7'd99;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_block(input int x, input logic [2:0] c);
      for (int py = 0; py < H_PIX; py++)
         for (int px = 0; px < W_PIX; px++)
            exp_q.push_back('{x: 8'(x + px), y: 7'(99 + py), c: c});
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Pixel scoreboard and pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (resetn) begin
         if (setAState)   cnt_a++;
         if (setDState)   cnt_d++;
         if (updateState) cnt_upd++;
         if (inputState)  cnt_in++;
         if (plot) begin
            cnt_plot++;
            if (first_plot_cyc < 0) first_plot_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("plot_without_expectation", 32'(plot), 32'd0);
            end else begin
               mon_exp = exp_q.pop_front();
               check("pixel", 32'({vga_x, vga_y, vga_colour}), 32'(mon_exp));
            end
         end
      end
   end

   // One frame: tick, optional mid-sequence tick or reset, then scoreboard checks.
   task automatic do_frame(input bit a, input bit d, input int tick_at, input int rst_at,
                           output int n);
      int exp_cycles, exp_lat, exp_pix;
      int a0, d0, u0, i0, p0, tick_cyc;
      exp_pix = 0;
      exp_lat = -1;
      if (a || d) begin
         push_block(lane_x(m_idx), 3'd0);
         if (a) m_idx = (m_idx > 0) ? m_idx - 1 : 0;
         else   m_idx = (m_idx < 3) ? m_idx + 1 : 3;
         push_block(lane_x(m_idx), 3'd7);
         exp_cycles = 4 + 2 * PIX;
         exp_lat    = 2;
         exp_pix    = 2 * PIX;
         m_need     = 1'b0;
      end else if (m_need) begin
         push_block(lane_x(m_idx), 3'd7);
         exp_cycles = 3 + PIX;
         exp_lat    = 3;
         exp_pix    = PIX;
         m_need     = 1'b0;
      end else begin
         exp_cycles = 2;
      end
      a0 = cnt_a; d0 = cnt_d; u0 = cnt_upd; i0 = cnt_in; p0 = cnt_plot;
      @(negedge clk);
      key_a = a; key_d = d; frame_tick = 1'b1;
      tick_cyc = cyc;
      first_plot_cyc = -1;
      @(negedge clk);
      frame_tick = 1'b0;
      n = 1;
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
         frame_tick = (n == tick_at);
         if (n == rst_at) begin
            #2 resetn = 1'b0;
            #1;
            check("plot_after_reset", 32'(plot), 32'd0);
            check("busy_after_reset", 32'(busy), 32'd0);
            exp_q.delete();
            m_idx  = 0;
            m_need = 1'b1;
            key_a = 1'b0; key_d = 1'b0; frame_tick = 1'b0;
            repeat (2) @(negedge clk);
            resetn = 1'b1;
            return;
         end
      end
      frame_tick = 1'b0;
      key_a = 1'b0; key_d = 1'b0;
      check("frame_cycles", 32'(n), 32'(exp_cycles));
      repeat (4) @(negedge clk);
      check("idle_after_frame", 32'(busy), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("input_pulses", 32'(cnt_in - i0), 32'd1);
      check("setA_pulses", 32'(cnt_a - a0), 32'(a));
      check("setD_pulses", 32'(cnt_d - d0), 32'(!a && d));
      check("update_pulses", 32'(cnt_upd - u0), 32'(a || d));
      check("plot_cycles", 32'(cnt_plot - p0), 32'(exp_pix));
      if (exp_lat >= 0) check("first_plot_latency", 32'(first_plot_cyc - tick_cyc), 32'(exp_lat));
   endtask

   initial begin
      int n;
      resetn = 1'b0; frame_tick = 1'b0; key_a = 1'b0; key_d = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_plot", 32'(plot), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_pulses", 32'({inputState, setAState, setDState, updateState}), 32'd0);
      check("reset_vga", 32'({vga_x, vga_y, vga_colour}), 32'd0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      do_frame(1'b0, 1'b0, -1, -1, n);            // initial draw at x 14
      check("initial_draw_cycles", 32'(n), 32'd99);
      check("colour_held", 32'(vga_colour), 32'd7);
      do_frame(1'b0, 1'b0, -1, -1, n);            // nothing to do
      check("idle_tick_cycles", 32'(n), 32'd2);

      do_frame(1'b0, 1'b1, -1, -1, n);            // D: 14 -> 54
      check("d_move_cycles", 32'(n), 32'd196);
      check("d_move_x", 32'(x_current), 32'd54);

      do_frame(1'b1, 1'b1, -1, -1, n);            // A+D: A wins, 54 -> 14
      check("ad_move_x", 32'(x_current), 32'd14);

      do_frame(1'b1, 1'b0, -1, -1, n);            // A at left edge: stays at 14
      check("edge_move_x", 32'(x_current), 32'd14);

      do_frame(1'b0, 1'b1, 140, -1, n);           // tick during draw pixel 40 is dropped
      check("dropped_tick_x", 32'(x_current), 32'd54);

      do_frame(1'b0, 1'b1, -1, 52, n);            // reset during erase pixel 50
      repeat (2) @(negedge clk);
      do_frame(1'b0, 1'b0, -1, -1, n);            // full redraw after reset
      check("redraw_after_reset_cycles", 32'(n), 32'd99);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
